// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the fetch/decode front end: default field widths,
// fixed decode bit positions and the queue handshake classification.
package cpu_isa_pkg;

    localparam int ISA_DATA_W   = 16;
    localparam int ISA_OP_W     = 4;
    localparam int ISA_REG_W    = 4;
    localparam int ISA_IMM_W    = 8;
    localparam int ISA_FQ_DEPTH = 4;

    localparam int LMC_BIT = 3;
    localparam int CC_MSB  = 2;
    localparam int CC_W    = CC_MSB + 1;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'b00,
        FQ_PUSH = 2'b01,
        FQ_POP  = 2'b10,
        FQ_BOTH = 2'b11
    } fq_op_e;

    function automatic fq_op_e fq_classify(input logic push, input logic pop);
        return fq_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/instr_decode_fields.sv
// Purely combinational slicer that splits an instruction word into its
// opcode, register, flag and immediate fields.
module instr_decode_fields
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W = ISA_DATA_W,
    parameter int OP_W   = ISA_OP_W,
    parameter int REG_W  = ISA_REG_W,
    parameter int IMM_W  = ISA_IMM_W
) (
    input  logic [DATA_W-1:0] instr_i,
    output logic [OP_W-1:0]   op_o,
    output logic [REG_W-1:0]  r1_o,
    output logic [REG_W-1:0]  r2_o,
    output logic              lmc_o,
    output logic [CC_W-1:0]   cc_o,
    output logic [DATA_W-1:0] signe_o,
    output logic [DATA_W-1:0] upper_o
);

    localparam int R1_MSB = DATA_W - OP_W - 1;
    localparam int R2_MSB = R1_MSB - REG_W;

    assign op_o    = instr_i[DATA_W-1 -: OP_W];
    assign r1_o    = instr_i[R1_MSB -: REG_W];
    assign r2_o    = instr_i[R2_MSB -: REG_W];
    assign lmc_o   = instr_i[LMC_BIT];
    assign cc_o    = instr_i[CC_MSB:0];
    assign signe_o = {{(DATA_W-IMM_W){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0]};
    assign upper_o = {instr_i[IMM_W-1:0], {(DATA_W-IMM_W){1'b0}}};

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular instruction queue with registered decode of the head entry; the
// decode registers reload only when the head changes and hold otherwise.
module instr_fetch_queue
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W = ISA_DATA_W,
    parameter int DEPTH  = ISA_FQ_DEPTH,
    parameter int OP_W   = ISA_OP_W,
    parameter int REG_W  = ISA_REG_W,
    parameter int IMM_W  = ISA_IMM_W
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [OP_W-1:0]          Op,
    output logic [REG_W-1:0]         r1,
    output logic [REG_W-1:0]         r2,
    output logic                     LMC,
    output logic [CC_W-1:0]          CC,
    output logic [DATA_W-1:0]        signE,
    output logic [DATA_W-1:0]        upper
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;
    logic              head_load;
    logic [DATA_W-1:0] head_src;
    fq_op_e            q_op;

    logic [OP_W-1:0]   op_q, op_d;
    logic [REG_W-1:0]  r1_q, r1_d;
    logic [REG_W-1:0]  r2_q, r2_d;
    logic              lmc_q, lmc_d;
    logic [CC_W-1:0]   cc_q, cc_d;
    logic [DATA_W-1:0] signe_q, signe_d;
    logic [DATA_W-1:0] upper_q, upper_d;

    // Handshake: full and empty come only from the registered count, so a
    // same-cycle pop never frees a full slot and an empty queue never bypasses.
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign q_op      = fq_classify(push, pop);
    assign rd_nxt    = rd_ptr_q + PTR_W'(1);
    assign count     = cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        head_load = 1'b0;
        head_src  = in_instr;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            unique case (q_op)
                FQ_PUSH: begin
                    wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                    cnt_d     = cnt_q + CNT_W'(1);
                    head_load = (cnt_q == '0);
                end
                FQ_POP: begin
                    rd_ptr_d  = rd_nxt;
                    cnt_d     = cnt_q - CNT_W'(1);
                    head_load = (cnt_q > CNT_W'(1));
                    head_src  = mem_q[rd_nxt];
                end
                FQ_BOTH: begin
                    // With a single entry the word being pushed becomes the new head.
                    wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d  = rd_nxt;
                    head_load = 1'b1;
                    head_src  = (cnt_q > CNT_W'(1)) ? mem_q[rd_nxt] : in_instr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    instr_decode_fields #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .REG_W  (REG_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .instr_i (head_src),
        .op_o    (op_d),
        .r1_o    (r1_d),
        .r2_o    (r2_d),
        .lmc_o   (lmc_d),
        .cc_o    (cc_d),
        .signe_o (signe_d),
        .upper_o (upper_d)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            lmc_q   <= 1'b0;
            cc_q    <= '0;
            signe_q <= '0;
            upper_q <= '0;
        end else if (head_load) begin
            op_q    <= op_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            lmc_q   <= lmc_d;
            cc_q    <= cc_d;
            signe_q <= signe_d;
            upper_q <= upper_d;
        end
    end

    assign Op    = op_q;
    assign r1    = r1_q;
    assign r2    = r2_q;
    assign LMC   = lmc_q;
    assign CC    = cc_q;
    assign signE = signe_q;
    assign upper = upper_q;

endmodule
